// File: rtl/run_decoder.sv
// JPEG run-length decoder: expands (DC, AC run/size/value, ZRL, EOB) symbols into
// 64 zigzag-ordered signed coefficients per block, one per output handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// ACCEPT | waiting for a symbol; output register empty or draining
// ZEROS  | emitting the zeros of a run (ZRL or run before a value)
// VALUE  | emitting the decoded value that follows a run
// FILL   | emitting zeros after EOB (or a malformed symbol) up to idx 63
module run_decoder #(
  parameter int COEF_W    = 11,
  parameter int BLOCK_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic [COEF_W-1:0] sym_dc_val,
  input  logic [3:0]        sym_run,
  input  logic [3:0]        sym_size,
  input  logic [9:0]        sym_val,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [COEF_W-1:0] coef,
  output logic [5:0]        coef_idx,
  output logic              coef_last,
  output logic              expect_dc,
  output logic              err
);

  localparam logic [5:0] LAST_IDX = 6'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_ZEROS  = 2'd1,
    S_VALUE  = 2'd2,
    S_FILL   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [5:0]        idx_q;
  logic [4:0]        zrun_q, zrun_nxt;
  logic              has_val_q, has_val_nxt;
  logic [COEF_W-1:0] val_q, val_nxt;
  logic              err_nxt;

  logic              out_free;
  logic              sym_fire;
  logic              at_end;
  logic              emit;
  logic [COEF_W-1:0] emit_coef;

  logic [COEF_W-1:0] mask;
  logic [COEF_W-1:0] msb_mask;
  logic [COEF_W-1:0] vbits;
  logic [COEF_W-1:0] ac_value;
  logic              is_eob;
  logic              is_zrl;
  logic              is_bad;
  logic              overflow;

  // idx_q is the index of the next coefficient to load; it wraps to 0 once
  // index 63 is loaded, which is exactly when the next symbol must be DC.
  assign expect_dc = (idx_q == 6'd0);
  assign out_free  = !coef_valid || coef_ready;
  assign sym_ready = !rst && (state == S_ACCEPT) && out_free;
  assign sym_fire  = sym_valid && sym_ready;
  assign at_end    = (idx_q == LAST_IDX);

  // Ones-complement decode: negative values are stored as value + (2^s - 1).
  always_comb begin
    mask     = (COEF_W'(1) << sym_size) - COEF_W'(1);
    msb_mask = mask ^ (mask >> 1);
    vbits    = COEF_W'(sym_val) & mask;
    if ((vbits & msb_mask) != '0) ac_value = vbits;
    else                          ac_value = vbits - mask;
  end

  assign is_eob   = (sym_size == 4'd0) && (sym_run == 4'd0);
  assign is_zrl   = (sym_size == 4'd0) && (sym_run == 4'd15);
  assign is_bad   = (sym_size > 4'd10) || ((sym_size == 4'd0) && !is_eob && !is_zrl);
  assign overflow = ({1'b0, idx_q} + {3'b000, sym_run}) > {1'b0, LAST_IDX};

  always_comb begin
    state_nxt   = state;
    zrun_nxt    = zrun_q;
    has_val_nxt = has_val_q;
    val_nxt     = val_q;
    err_nxt     = err;
    emit        = 1'b0;
    emit_coef   = '0;

    case (state)
      S_ACCEPT: begin
        if (sym_fire) begin
          emit = 1'b1;
          if (expect_dc) begin
            emit_coef = sym_dc_val;
          end else if (is_eob || is_bad) begin
            if (is_bad) err_nxt = 1'b1;
            state_nxt = at_end ? S_ACCEPT : S_FILL;
          end else if (is_zrl) begin
            if (overflow) err_nxt = 1'b1;
            zrun_nxt    = 5'd15;
            has_val_nxt = 1'b0;
            state_nxt   = at_end ? S_ACCEPT : S_ZEROS;
          end else if (sym_run == 4'd0) begin
            emit_coef = ac_value;
          end else begin
            if (overflow) err_nxt = 1'b1;
            zrun_nxt    = {1'b0, sym_run} - 5'd1;
            has_val_nxt = 1'b1;
            val_nxt     = ac_value;
            if (at_end)                  state_nxt = S_ACCEPT;
            else if (sym_run == 4'd1)    state_nxt = S_VALUE;
            else                         state_nxt = S_ZEROS;
          end
        end
      end
      S_ZEROS: begin
        if (out_free) begin
          emit     = 1'b1;
          zrun_nxt = zrun_q - 5'd1;
          // Reaching idx 63 ends the block; a pending value beyond it is dropped.
          if (at_end)                state_nxt = S_ACCEPT;
          else if (zrun_q == 5'd1)   state_nxt = has_val_q ? S_VALUE : S_ACCEPT;
        end
      end
      S_VALUE: begin
        if (out_free) begin
          emit      = 1'b1;
          emit_coef = val_q;
          state_nxt = S_ACCEPT;
        end
      end
      S_FILL: begin
        if (out_free) begin
          emit = 1'b1;
          if (at_end) state_nxt = S_ACCEPT;
        end
      end
      default: state_nxt = S_ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ACCEPT;
      idx_q      <= '0;
      zrun_q     <= '0;
      has_val_q  <= 1'b0;
      val_q      <= '0;
      err        <= 1'b0;
      coef_valid <= 1'b0;
      coef       <= '0;
      coef_idx   <= '0;
      coef_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      zrun_q    <= zrun_nxt;
      has_val_q <= has_val_nxt;
      val_q     <= val_nxt;
      err       <= err_nxt;
      if (emit) begin
        coef_valid <= 1'b1;
        coef       <= emit_coef;
        coef_idx   <= idx_q;
        coef_last  <= at_end;
        idx_q      <= idx_q + 6'd1;
      end else if (coef_ready) begin
        coef_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_run_decoder.sv
// Directed self-checking bench for run_decoder: expected blocks are written out
// by hand per scenario and compared against captured output transfers.
module tb_run_decoder;

  logic              clk;
  logic              rst;
  logic              sym_valid;
  logic              sym_ready;
  logic [10:0]       sym_dc_val;
  logic [3:0]        sym_run;
  logic [3:0]        sym_size;
  logic [9:0]        sym_val;
  logic              coef_valid;
  logic              coef_ready;
  logic [10:0]       coef;
  logic [5:0]        coef_idx;
  logic              coef_last;
  logic              expect_dc;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [10:0] cap_coef[$];
  logic [5:0]         cap_idx[$];
  logic               cap_last[$];
  logic signed [10:0] exp_c[64];

  run_decoder #(.COEF_W(11), .BLOCK_LEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_dc_val (sym_dc_val),
    .sym_run    (sym_run),
    .sym_size   (sym_size),
    .sym_val    (sym_val),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef       (coef),
    .coef_idx   (coef_idx),
    .coef_last  (coef_last),
    .expect_dc  (expect_dc),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change only at posedge+1, so a handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && coef_valid && coef_ready) begin
      cap_coef.push_back(coef);
      cap_idx.push_back(coef_idx);
      cap_last.push_back(coef_last);
    end
  end

  task automatic clear_caps();
    cap_coef.delete();
    cap_idx.delete();
    cap_last.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_caps();
  endtask

  task automatic send_sym(input logic [10:0] dc, input logic [3:0] run,
                          input logic [3:0] size, input logic [9:0] val);
    bit done;
    done = 1'b0;
    sym_dc_val = dc;
    sym_run    = run;
    sym_size   = size;
    sym_val    = val;
    sym_valid  = 1'b1;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (sym_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    sym_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL sym_handshake timeout: sym_ready never 1, required 1");
    end
  endtask

  task automatic wait_caps(input int n);
    for (int k = 0; k < 2000 && cap_coef.size() < n; k++) begin
      @(posedge clk);
      #1;
    end
    if (cap_coef.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_caps: got %0d coefs, required %0d", cap_coef.size(), n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sym_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (coef_valid !== 1'b0) begin n_bad++; $display("FAIL rst coef_valid: got %0b, required 0", coef_valid); end
    n_cmp++; if (coef !== 11'd0)      begin n_bad++; $display("FAIL rst coef: got %0d, required 0", coef); end
    n_cmp++; if (coef_idx !== 6'd0)   begin n_bad++; $display("FAIL rst coef_idx: got %0d, required 0", coef_idx); end
    n_cmp++; if (coef_last !== 1'b0)  begin n_bad++; $display("FAIL rst coef_last: got %0b, required 0", coef_last); end
    n_cmp++; if (err !== 1'b0)        begin n_bad++; $display("FAIL rst err: got %0b, required 0", err); end
    n_cmp++; if (expect_dc !== 1'b1)  begin n_bad++; $display("FAIL rst expect_dc: got %0b, required 1", expect_dc); end
    n_cmp++; if (sym_ready !== 1'b0)  begin n_bad++; $display("FAIL rst sym_ready: got %0b, required 0", sym_ready); end
    sym_valid = 1'b0;
    rst = 1'b0;
    clear_caps();
  endtask

  task automatic test_dc_eob();
    for (int i = 0; i < 64; i++) exp_c[i] = 11'sd0;
    exp_c[0] = -11'sd5;
    send_sym(11'h7fb, 4'd0, 4'd0, 10'd0);
    send_sym(11'd0, 4'd0, 4'd0, 10'd0);
    wait_caps(64);
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (i >= cap_coef.size()) begin n_bad++; $display("FAIL dc_eob idx %0d: missing, required %0d", i, exp_c[i]); end
      else if (cap_coef[i] !== exp_c[i] || cap_idx[i] !== 6'(i) || cap_last[i] !== (i == 63)) begin
        n_bad++;
        $display("FAIL dc_eob idx %0d: got coef %0d idx %0d last %0b, required %0d %0d %0b",
                 i, cap_coef[i], cap_idx[i], cap_last[i], exp_c[i], i, (i == 63));
      end
    end
    n_cmp++; if (cap_coef.size() != 64) begin n_bad++; $display("FAIL dc_eob count: got %0d, required 64", cap_coef.size()); end
    n_cmp++; if (expect_dc !== 1'b1)   begin n_bad++; $display("FAIL dc_eob expect_dc: got %0b, required 1", expect_dc); end
    n_cmp++; if (err !== 1'b0)         begin n_bad++; $display("FAIL dc_eob err: got %0b, required 0", err); end
    n_cmp++; if (coef_valid !== 1'b0)  begin n_bad++; $display("FAIL dc_eob idle coef_valid: got %0b, required 0", coef_valid); end
    clear_caps();
  endtask

  task automatic test_ac_values();
    for (int i = 0; i < 64; i++) exp_c[i] = 11'sd0;
    exp_c[3] = -11'sd5;
    exp_c[4] = 11'sd5;
    send_sym(11'd0, 4'd0, 4'd0, 10'd0);
    send_sym(11'd0, 4'd2, 4'd3, 10'b010);
    send_sym(11'd0, 4'd0, 4'd3, 10'b101);
    send_sym(11'd0, 4'd0, 4'd0, 10'd0);
    wait_caps(64);
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (i >= cap_coef.size()) begin n_bad++; $display("FAIL ac_values idx %0d: missing, required %0d", i, exp_c[i]); end
      else if (cap_coef[i] !== exp_c[i] || cap_idx[i] !== 6'(i) || cap_last[i] !== (i == 63)) begin
        n_bad++;
        $display("FAIL ac_values idx %0d: got coef %0d idx %0d last %0b, required %0d %0d %0b",
                 i, cap_coef[i], cap_idx[i], cap_last[i], exp_c[i], i, (i == 63));
      end
    end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ac_values err: got %0b, required 0", err); end
    clear_caps();
  endtask

  task automatic test_size_extremes();
    for (int i = 0; i < 64; i++) exp_c[i] = 11'sd0;
    exp_c[1] = -11'sd1023;
    exp_c[2] = 11'sd1023;
    exp_c[3] = -11'sd9;
    exp_c[6] = -11'sd1;
    send_sym(11'd0, 4'd0, 4'd0, 10'd0);
    send_sym(11'd0, 4'd0, 4'd10, 10'h000);
    send_sym(11'd0, 4'd0, 4'd10, 10'h3ff);
    send_sym(11'd0, 4'd0, 4'd4, 10'b1111110110);
    send_sym(11'd0, 4'd2, 4'd1, 10'b1111111110);
    send_sym(11'd0, 4'd0, 4'd0, 10'd0);
    wait_caps(64);
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (i >= cap_coef.size()) begin n_bad++; $display("FAIL size_ext idx %0d: missing, required %0d", i, exp_c[i]); end
      else if (cap_coef[i] !== exp_c[i] || cap_idx[i] !== 6'(i) || cap_last[i] !== (i == 63)) begin
        n_bad++;
        $display("FAIL size_ext idx %0d: got coef %0d idx %0d last %0b, required %0d %0d %0b",
                 i, cap_coef[i], cap_idx[i], cap_last[i], exp_c[i], i, (i == 63));
      end
    end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL size_ext err: got %0b, required 0", err); end
    clear_caps();
  endtask

  task automatic test_zrl();
    for (int i = 0; i < 64; i++) exp_c[i] = 11'sd0;
    exp_c[0]  = 11'sd7;
    exp_c[17] = 11'sd1;
    send_sym(11'd7, 4'd0, 4'd0, 10'd0);
    send_sym(11'd0, 4'd15, 4'd0, 10'd0);
    // Cycle after the ZRL handshake: first zero already presented.
    n_cmp++;
    if (coef_valid !== 1'b1 || coef_idx !== 6'd1 || coef !== 11'd0) begin
      n_bad++;
      $display("FAIL zrl latency: got valid %0b idx %0d coef %0d, required 1 1 0", coef_valid, coef_idx, coef);
    end
    n_cmp++; if (sym_ready !== 1'b0) begin n_bad++; $display("FAIL zrl sym_ready: got %0b, required 0", sym_ready); end
    send_sym(11'd0, 4'd0, 4'd1, 10'd1);
    send_sym(11'd0, 4'd0, 4'd0, 10'd0);
    wait_caps(64);
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (i >= cap_coef.size()) begin n_bad++; $display("FAIL zrl idx %0d: missing, required %0d", i, exp_c[i]); end
      else if (cap_coef[i] !== exp_c[i] || cap_idx[i] !== 6'(i) || cap_last[i] !== (i == 63)) begin
        n_bad++;
        $display("FAIL zrl idx %0d: got coef %0d idx %0d last %0b, required %0d %0d %0b",
                 i, cap_coef[i], cap_idx[i], cap_last[i], exp_c[i], i, (i == 63));
      end
    end
    clear_caps();
  endtask

  task automatic test_full_block();
    exp_c[0] = 11'sd1;
    for (int i = 1; i < 64; i++) exp_c[i] = -11'sd1;
    send_sym(11'd1, 4'd0, 4'd0, 10'd0);
    for (int i = 1; i < 64; i++) send_sym(11'd0, 4'd0, 4'd1, 10'd0);
    n_cmp++; if (expect_dc !== 1'b1) begin n_bad++; $display("FAIL full expect_dc: got %0b, required 1", expect_dc); end
    send_sym(11'd3, 4'd0, 4'd0, 10'd0);
    wait_caps(65);
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (i >= cap_coef.size()) begin n_bad++; $display("FAIL full idx %0d: missing, required %0d", i, exp_c[i]); end
      else if (cap_coef[i] !== exp_c[i] || cap_idx[i] !== 6'(i) || cap_last[i] !== (i == 63)) begin
        n_bad++;
        $display("FAIL full idx %0d: got coef %0d idx %0d last %0b, required %0d %0d %0b",
                 i, cap_coef[i], cap_idx[i], cap_last[i], exp_c[i], i, (i == 63));
      end
    end
    n_cmp++;
    if (cap_coef.size() < 65) begin n_bad++; $display("FAIL next_dc: missing, required 3 at idx 0"); end
    else if (cap_coef[64] !== 11'sd3 || cap_idx[64] !== 6'd0) begin
      n_bad++;
      $display("FAIL next_dc: got coef %0d idx %0d, required 3 0", cap_coef[64], cap_idx[64]);
    end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL full err: got %0b, required 0", err); end
    send_sym(11'd0, 4'd0, 4'd0, 10'd0);
    wait_caps(128);
    clear_caps();
  endtask

  task automatic test_back_pressure();
    logic [10:0] h_coef;
    logic [5:0]  h_idx;
    for (int i = 0; i < 64; i++) exp_c[i] = 11'sd0;
    exp_c[6] = 11'sd3;
    send_sym(11'd0, 4'd0, 4'd0, 10'd0);
    send_sym(11'd0, 4'd5, 4'd2, 10'b11);
    @(posedge clk);
    #1;
    coef_ready = 1'b0;
    h_coef = coef;
    h_idx  = coef_idx;
    n_cmp++; if (h_idx !== 6'd2) begin n_bad++; $display("FAIL bp hold idx start: got %0d, required 2", h_idx); end
    repeat (3) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (coef_valid !== 1'b1 || coef !== h_coef || coef_idx !== h_idx || sym_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp hold: got valid %0b coef %0d idx %0d sym_ready %0b, required 1 %0d %0d 0",
                 coef_valid, coef, coef_idx, sym_ready, h_coef, h_idx);
      end
    end
    coef_ready = 1'b1;
    send_sym(11'd0, 4'd0, 4'd0, 10'd0);
    wait_caps(64);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (cap_coef.size() != 64) begin n_bad++; $display("FAIL bp count: got %0d, required 64", cap_coef.size()); end
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (i >= cap_coef.size()) begin n_bad++; $display("FAIL bp idx %0d: missing, required %0d", i, exp_c[i]); end
      else if (cap_coef[i] !== exp_c[i] || cap_idx[i] !== 6'(i) || cap_last[i] !== (i == 63)) begin
        n_bad++;
        $display("FAIL bp idx %0d: got coef %0d idx %0d last %0b, required %0d %0d %0b",
                 i, cap_coef[i], cap_idx[i], cap_last[i], exp_c[i], i, (i == 63));
      end
    end
    clear_caps();
  endtask

  task automatic test_overflow();
    exp_c[0] = 11'sd0;
    for (int i = 1; i < 62; i++) exp_c[i] = 11'sd1;
    exp_c[62] = 11'sd0;
    exp_c[63] = 11'sd0;
    send_sym(11'd0, 4'd0, 4'd0, 10'd0);
    for (int i = 1; i < 62; i++) send_sym(11'd0, 4'd0, 4'd1, 10'd1);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ovf err before: got %0b, required 0", err); end
    send_sym(11'd0, 4'd5, 4'd1, 10'd1);
    wait_caps(64);
    n_cmp++; if (cap_coef.size() != 64) begin n_bad++; $display("FAIL ovf count: got %0d, required 64", cap_coef.size()); end
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (i >= cap_coef.size()) begin n_bad++; $display("FAIL ovf idx %0d: missing, required %0d", i, exp_c[i]); end
      else if (cap_coef[i] !== exp_c[i] || cap_idx[i] !== 6'(i) || cap_last[i] !== (i == 63)) begin
        n_bad++;
        $display("FAIL ovf idx %0d: got coef %0d idx %0d last %0b, required %0d %0d %0b",
                 i, cap_coef[i], cap_idx[i], cap_last[i], exp_c[i], i, (i == 63));
      end
    end
    n_cmp++; if (err !== 1'b1)       begin n_bad++; $display("FAIL ovf err: got %0b, required 1", err); end
    n_cmp++; if (expect_dc !== 1'b1) begin n_bad++; $display("FAIL ovf expect_dc: got %0b, required 1", expect_dc); end
    clear_caps();
  endtask

  task automatic test_mid_reset();
    bit hit;
    hit = 1'b0;
    send_sym(11'd9, 4'd0, 4'd0, 10'd0);
    send_sym(11'd0, 4'd0, 4'd0, 10'd0);
    for (int k = 0; k < 200 && !hit; k++) begin
      if (coef_valid && coef_idx == 6'd30) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL mid_rst reach idx30: got 0, required 1"); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (coef_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst coef_valid: got %0b, required 0", coef_valid); end
    n_cmp++; if (expect_dc !== 1'b1)  begin n_bad++; $display("FAIL mid_rst expect_dc: got %0b, required 1", expect_dc); end
    n_cmp++; if (err !== 1'b0)        begin n_bad++; $display("FAIL mid_rst err: got %0b, required 0", err); end
    rst = 1'b0;
    clear_caps();
    for (int i = 0; i < 64; i++) exp_c[i] = 11'sd0;
    exp_c[0] = 11'sd2;
    send_sym(11'd2, 4'd0, 4'd0, 10'd0);
    send_sym(11'd0, 4'd0, 4'd0, 10'd0);
    wait_caps(64);
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (i >= cap_coef.size()) begin n_bad++; $display("FAIL mid_rst idx %0d: missing, required %0d", i, exp_c[i]); end
      else if (cap_coef[i] !== exp_c[i] || cap_idx[i] !== 6'(i) || cap_last[i] !== (i == 63)) begin
        n_bad++;
        $display("FAIL mid_rst idx %0d: got coef %0d idx %0d last %0b, required %0d %0d %0b",
                 i, cap_coef[i], cap_idx[i], cap_last[i], exp_c[i], i, (i == 63));
      end
    end
    clear_caps();
  endtask

  task automatic test_bad_symbols();
    for (int i = 0; i < 64; i++) exp_c[i] = 11'sd0;
    exp_c[0] = 11'sd4;
    exp_c[2] = 11'sd1;
    send_sym(11'd4, 4'd0, 4'd0, 10'd0);
    send_sym(11'd0, 4'd1, 4'd1, 10'd1);
    send_sym(11'd0, 4'd3, 4'd0, 10'd0);
    wait_caps(64);
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (i >= cap_coef.size()) begin n_bad++; $display("FAIL bad_run idx %0d: missing, required %0d", i, exp_c[i]); end
      else if (cap_coef[i] !== exp_c[i] || cap_idx[i] !== 6'(i) || cap_last[i] !== (i == 63)) begin
        n_bad++;
        $display("FAIL bad_run idx %0d: got coef %0d idx %0d last %0b, required %0d %0d %0b",
                 i, cap_coef[i], cap_idx[i], cap_last[i], exp_c[i], i, (i == 63));
      end
    end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad_run err: got %0b, required 1", err); end

    do_reset();
    for (int i = 0; i < 64; i++) exp_c[i] = 11'sd0;
    exp_c[0] = -11'sd1024;
    send_sym(11'h400, 4'd0, 4'd0, 10'd0);
    send_sym(11'd0, 4'd0, 4'd11, 10'h3ff);
    wait_caps(64);
    for (int i = 0; i < 64; i++) begin
      n_cmp++;
      if (i >= cap_coef.size()) begin n_bad++; $display("FAIL bad_size idx %0d: missing, required %0d", i, exp_c[i]); end
      else if (cap_coef[i] !== exp_c[i] || cap_idx[i] !== 6'(i) || cap_last[i] !== (i == 63)) begin
        n_bad++;
        $display("FAIL bad_size idx %0d: got coef %0d idx %0d last %0b, required %0d %0d %0b",
                 i, cap_coef[i], cap_idx[i], cap_last[i], exp_c[i], i, (i == 63));
      end
    end
    n_cmp++; if (err !== 1'b1)       begin n_bad++; $display("FAIL bad_size err: got %0b, required 1", err); end
    n_cmp++; if (expect_dc !== 1'b1) begin n_bad++; $display("FAIL bad_size expect_dc: got %0b, required 1", expect_dc); end
    clear_caps();
  endtask

  initial begin
    rst        = 1'b1;
    sym_valid  = 1'b0;
    sym_dc_val = '0;
    sym_run    = '0;
    sym_size   = '0;
    sym_val    = '0;
    coef_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_dc_eob();
    test_ac_values();
    test_size_extremes();
    test_zrl();
    test_full_block();
    test_back_pressure();
    test_overflow();
    test_mid_reset();
    test_bad_symbols();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
